fetch_unit: RTL and testbench

//  Instruction fetch stage. Holds the PC, issues word reads to instruction memory,

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request issue, in-order instruction buffer, redirect flush.
// Optional build macro FETCH_STALL_COUNT_EN adds a stall_count output (cycles with nothing to decode).
module fetch_unit #(
  parameter int                   ADDR_BITS  = 32,
  parameter logic [ADDR_BITS-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDR_BITS-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [31:0]          imem_resp_data,
  input  logic                 redirect_valid,
  input  logic [ADDR_BITS-1:0] redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [ADDR_BITS-1:0] instr_pc,
  output logic [ADDR_BITS-1:0] instr_pc_plus8
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]          stall_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [ADDR_BITS-1:0] fetch_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        drop_count;
  logic [CW-1:0]        fifo_count;
  logic [PW-1:0]        fifo_wr;
  logic [PW-1:0]        fifo_rd;
  logic [PW-1:0]        pcq_wr;
  logic [PW-1:0]        pcq_rd;
  logic [31:0]          fifo_data [FIFO_DEPTH];
  logic [ADDR_BITS-1:0] fifo_pc   [FIFO_DEPTH];
  logic [ADDR_BITS-1:0] pcq       [FIFO_DEPTH];
  logic [CW:0]          in_flight;
  logic                 pop;
  logic                 accept;
  logic                 push;

  // Outstanding requests count against buffer space, so every returning word always has a slot.
  always_comb begin
    instr_valid    = (fifo_count != '0) && !redirect_valid;
    pop            = instr_valid && instr_ready;
    in_flight      = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
    imem_req_valid = !reset && !redirect_valid && (in_flight < DEPTH_W);
    accept         = imem_req_valid && imem_req_ready;
    push           = imem_resp_valid && !redirect_valid && (drop_count == '0);
  end

  assign imem_req_addr  = fetch_pc;
  assign instr          = fifo_data[fifo_rd];
  assign instr_pc       = fifo_pc[fifo_rd];
  assign instr_pc_plus8 = instr_pc + ADDR_BITS'(8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else if (redirect_valid) begin
      // Every request still in flight belongs to the old path; a response landing now is dropped too.
      fetch_pc    <= redirect_pc & ~(ADDR_BITS'(3));
      outstanding <= outstanding - CW'(imem_resp_valid);
      drop_count  <= outstanding - CW'(imem_resp_valid);
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + ADDR_BITS'(4);
        pcq_wr   <= pcq_wr + PW'(1);
      end
      if (imem_resp_valid && (drop_count != '0))
        drop_count <= drop_count - CW'(1);
      if (push) begin
        fifo_wr <= fifo_wr + PW'(1);
        pcq_rd  <= pcq_rd + PW'(1);
      end
      if (pop)
        fifo_rd <= fifo_rd + PW'(1);
      outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
      fifo_count  <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      pcq[pcq_wr] <= fetch_pc;
    if (push) begin
      fifo_data[fifo_wr] <= imem_resp_data;
      fifo_pc[fifo_wr]   <= pcq[pcq_rd];
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (!instr_valid && !redirect_valid)
      stall_count <= stall_count + 32'd1;
  end
`else
  // Stall counter is not built in this configuration.
`endif

  resp_needs_request: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected PCs, a negedge monitor checks deliveries.
// A small in-order memory model with programmable latency answers the fetch requests.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus8;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  int          cyc = 0;
  int          n_compared = 0;
  int          n_mism = 0;
  int          mem_lat = 1;
  int          first_valid_cyc = -1;
  int          acc_count = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus8 (instr_pc_plus8)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_of(logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mism++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic waitCycle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    mem_lat        = 1;
    waitCycle(2);
    first_valid_cyc = -1;
    acc_count       = 0;
  endtask

  task automatic releaseReset(output int r);
    waitCycle(1);
    reset = 1'b0;
    r     = cyc;
  endtask

  // Memory model: record accepted requests, answer them in order after mem_lat cycles.
  always @(negedge clk) begin
    if (reset)
      mq.delete();
    else if (imem_req_valid && imem_req_ready)
      mq.push_back('{imem_req_addr, cyc + mem_lat});
  end

  always @(posedge clk) begin
    #1;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = data_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  // Monitor: every handshake to decode must match the head of the expected queue.
  always @(negedge clk) begin
    logic [31:0] pc;
    if (!reset) begin
      if (instr_valid && first_valid_cyc < 0)
        first_valid_cyc = cyc;
      if (imem_req_valid && imem_req_ready)
        acc_count++;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mism++;
          $display("[TB] FAIL unexpected_instr: got pc %h, required none", instr_pc);
        end else begin
          pc = exp_q.pop_front();
          checkOutput("instr_pc", instr_pc, pc);
          checkOutput("instr", instr, data_of(pc));
          checkOutput("instr_pc_plus8", instr_pc_plus8, pc + 32'd8);
        end
      end
    end
  end

  task automatic applyStimulus(int phase);
    int r;
    logic [15:0] rpat;
    logic [15:0] ipat;
    bit done;
    case (phase)
      // Reset state, then a sustained one-per-cycle stream.
      0: begin
        applyReset();
        @(negedge clk);
        checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("reset_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("reset_req_addr", imem_req_addr, 32'h0);
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        releaseReset(r);
        waitCycle(10);
        instr_ready = 1'b0;
        checkOutput("first_valid_cycle", 32'(first_valid_cyc - r), 32'd2);
      end
      // Decode stalled: only FIFO_DEPTH requests, head held at pc 0.
      1: begin
        applyReset();
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
        releaseReset(r);
        waitCycle(2);
        @(negedge clk);
        checkOutput("hold_valid_early", 32'(instr_valid), 32'd1);
        checkOutput("hold_pc_early", instr_pc, 32'h0);
        waitCycle(2);
        @(negedge clk);
        checkOutput("hold_valid_late", 32'(instr_valid), 32'd1);
        checkOutput("hold_pc_late", instr_pc, 32'h0);
        checkOutput("hold_instr_late", instr, data_of(32'h0));
        waitCycle(1);
        checkOutput("hold_accept_count", 32'(acc_count), 32'd2);
        instr_ready = 1'b1;
        waitCycle(4);
        instr_ready = 1'b0;
      end
      // Redirect to 0x103 with two requests outstanding (3-cycle memory).
      2: begin
        applyReset();
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        releaseReset(r);
        waitCycle(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        @(negedge clk);
        checkOutput("redirect_req_valid", 32'(imem_req_valid), 32'd0);
        waitCycle(1);
        redirect_valid = 1'b0;
        waitCycle(7);
        instr_ready = 1'b0;
      end
      // Back-to-back redirects, the first one with a response arriving in that cycle.
      3: begin
        applyReset();
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        exp_q.push_back(32'h000);
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        releaseReset(r);
        waitCycle(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        waitCycle(1);
        redirect_pc    = 32'h300;
        waitCycle(1);
        redirect_valid = 1'b0;
        waitCycle(4);
        instr_ready = 1'b0;
      end
      // Address wrap past 0xFFFFFFFC, with low redirect bits ignored.
      4: begin
        applyReset();
        mem_lat        = 1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        releaseReset(r);
        @(negedge clk);
        checkOutput("stalled_req_addr", imem_req_addr, 32'h0);
        waitCycle(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("wrap_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        waitCycle(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        checkOutput("wrap_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("wrap_req_addr_hi", imem_req_addr, 32'hFFFF_FFFC);
        waitCycle(1);
        @(negedge clk);
        checkOutput("wrap_req_addr_lo", imem_req_addr, 32'h0);
        waitCycle(3);
        instr_ready = 1'b0;
      end
      // Toggling memory and decode readiness with a 3-cycle memory.
      5: begin
        applyReset();
        mem_lat = 3;
        rpat    = 16'b1011_0010_1110_0101;
        ipat    = 16'b1101_1110_0111_1011;
        for (int i = 0; i < 12; i++) exp_q.push_back(32'(4 * i));
        releaseReset(r);
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
          if (exp_q.size() == 0) begin
            done = 1'b1;
          end else begin
            imem_req_ready = rpat[cyc % 16];
            instr_ready    = ipat[cyc % 16];
            waitCycle(1);
          end
        end
        instr_ready = 1'b0;
        checkOutput("toggle_stream_done", 32'(done), 32'd1);
      end
`ifdef FETCH_STALL_COUNT_EN
      // Memory never ready for 10 cycles: every one of them is a stall cycle.
      6: begin
        applyReset();
        @(negedge clk);
        checkOutput("stall_count_reset", stall_count, 32'd0);
        mem_lat        = 1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        releaseReset(r);
        waitCycle(10);
        @(negedge clk);
        checkOutput("stall_count_10", stall_count, 32'd10);
      end
`endif
      default: ;
    endcase
    waitCycle(3);
    checkOutput("leftover_expected", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    for (int p = 0; p < 7; p++) applyStimulus(p);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mism);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
